// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Central stall/flush sequencer for the 5-stage RV32I pipeline. It merges
//   these stall and redirect sources:
//     - load-use stall
//     - IF fetch miss
//     - MEM wait
//     - branch/jump redirect
//     - multi-cycle mul/div occupancy
//   From them it produces, for each stage register, a write enable and a
//   bubble/flush control. All outputs are combinational from registered state
//   plus the current inputs, so a stall takes effect in the same cycle.
//
//   The block owns three pieces of state:
//     - the mul/div latency counter, with FSM states RUN / MD_BUSY / MD_HOLD
//     - the stale-fetch discard flag
//     - two saturating performance counters
//
// Parameters
//   MD_LAT  cycles a mul/div occupies EX (>=1; 1 means no stall)
//   CNT_W   width of the performance counters
//
// Ports
//   clk              clock, rising edge
//   rst              synchronous active-low reset
//   hd_stall_i       load-use hazard (ID depends on a load in EX)
//   if_miss_i        IF instruction response not valid yet
//   mem_busy_i       MEM data access outstanding
//   redirect_i       EX resolved a taken branch/jump
//   md_start_i       first cycle of a mul/div in EX
//   pc_write_o       PC write enable
//   if_id_write_o    IF/ID write enable
//   id_ex_write_o    ID/EX write enable
//   ex_mem_write_o   EX/MEM write enable
//   mem_wb_write_o   MEM/WB write enable
//   if_id_flush_o    load NOP into IF/ID
//   id_ex_bubble_o   zero the control fields entering ID/EX
//   ex_mem_bubble_o  load NOP into EX/MEM
//   mem_wb_bubble_o  load NOP into MEM/WB
//   md_done_o        mul/div result valid in EX this cycle
//   stall_cnt_o      cycles with pc_write_o==0 since reset (saturating)
//   flush_cnt_o      accepted redirects since reset (saturating)
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hd_stall_i,
    input  logic             if_miss_i,
    input  logic             mem_busy_i,
    input  logic             redirect_i,
    input  logic             md_start_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             id_ex_write_o,
    output logic             ex_mem_write_o,
    output logic             mem_wb_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             ex_mem_bubble_o,
    output logic             mem_wb_bubble_o,
    output logic             md_done_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // The counter holds the number of stall cycles left after the current
    // one, so its largest value is MD_LAT-2.
    localparam int               MD_CW    = (MD_LAT > 2) ? $clog2(MD_LAT - 1) : 1;
    localparam bit               MD_MULTI = (MD_LAT > 1);
    localparam logic [MD_CW-1:0] MD_INIT  = MD_MULTI ? MD_CW'(MD_LAT - 2) : '0;

    typedef enum logic [1:0] {
        S_RUN,
        S_MD_BUSY,
        S_MD_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [MD_CW-1:0]   md_cnt_q, md_cnt_d;
    logic               drop_q, drop_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               md_stall;
    logic               redirect_take;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        pc_write_o      = 1'b1;
        if_id_write_o   = 1'b1;
        id_ex_write_o   = 1'b1;
        ex_mem_write_o  = 1'b1;
        mem_wb_write_o  = 1'b1;
        if_id_flush_o   = 1'b0;
        id_ex_bubble_o  = 1'b0;
        ex_mem_bubble_o = 1'b0;
        mem_wb_bubble_o = 1'b0;
        md_done_o       = 1'b0;
        state_d         = state_q;
        md_cnt_d        = md_cnt_q;
        drop_d          = drop_q;
        stall_cnt_d     = stall_cnt_q;
        flush_cnt_d     = flush_cnt_q;
        redirect_take   = 1'b0;

        case (state_q)
            S_RUN:     md_done_o = !MD_MULTI && md_start_i;
            S_MD_BUSY: md_done_o = (md_cnt_q == '0);
            S_MD_HOLD: md_done_o = 1'b1;
            default:   md_done_o = 1'b0;
        endcase

        md_stall = (state_q == S_MD_BUSY && md_cnt_q != '0) ||
                   (state_q == S_RUN && md_start_i && MD_MULTI);

        // The stale-word discard sits below redirect and above the hazard
        // stall. While the flag is set, ID holds only flushed NOPs, so a
        // load-use hazard cannot coincide with it. While MEM or mul/div
        // freezes the front end, the discard simply waits.
        if (mem_busy_i) begin
            pc_write_o      = 1'b0;
            if_id_write_o   = 1'b0;
            id_ex_write_o   = 1'b0;
            ex_mem_write_o  = 1'b0;
            mem_wb_bubble_o = 1'b1;
        end else if (md_stall) begin
            pc_write_o      = 1'b0;
            if_id_write_o   = 1'b0;
            id_ex_write_o   = 1'b0;
            ex_mem_bubble_o = 1'b1;
        end else if (redirect_i) begin
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
            redirect_take  = 1'b1;
            // A fetch still in flight belongs to the wrong path. A word that
            // arrives now is flushed here, so the flag only tracks a pending
            // miss.
            drop_d         = if_miss_i;
        end else if (drop_q && !if_miss_i) begin
            if_id_flush_o = 1'b1;
            drop_d        = 1'b0;
        end else if (hd_stall_i) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_bubble_o = 1'b1;
        end else if (if_miss_i) begin
            pc_write_o    = 1'b0;
            if_id_flush_o = 1'b1;
        end

        case (state_q)
            S_RUN: begin
                if (MD_MULTI && md_start_i && !mem_busy_i) begin
                    state_d  = S_MD_BUSY;
                    md_cnt_d = MD_INIT;
                end
            end
            S_MD_BUSY: begin
                // The latency counter keeps running under a MEM stall; only
                // the release back to RUN waits for MEM.
                if (md_cnt_q != '0) begin
                    md_cnt_d = md_cnt_q - MD_CW'(1);
                end else begin
                    state_d = mem_busy_i ? S_MD_HOLD : S_RUN;
                end
            end
            S_MD_HOLD: begin
                if (!mem_busy_i) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase

        if (!pc_write_o) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
        if (redirect_take) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end

        if (!rst) begin
            pc_write_o      = 1'b0;
            if_id_write_o   = 1'b0;
            id_ex_write_o   = 1'b0;
            ex_mem_write_o  = 1'b0;
            mem_wb_write_o  = 1'b0;
            if_id_flush_o   = 1'b1;
            id_ex_bubble_o  = 1'b1;
            ex_mem_bubble_o = 1'b1;
            mem_wb_bubble_o = 1'b1;
            md_done_o       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_RUN;
            md_cnt_q    <= '0;
            drop_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            drop_q      <= drop_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst;
    logic hd_stall_i, if_miss_i, mem_busy_i, redirect_i, md_start_i;

    // Output bit order: {pc, if_id_w, id_ex_w, ex_mem_w, mem_wb_w,
    //                    if_id_flush, id_ex_bubble, ex_mem_bubble, mem_wb_bubble, md_done}
    logic [9:0]       o4, o1;
    logic [CNT_W-1:0] sc4, fc4, sc1, fc1;

    int n_vec;
    int n_fail;

    typedef struct {
        int md_left;   // cycles the mul/div still occupies EX, counting the current one
        bit drop;      // stale fetch response still to be thrown away
        int scnt;
        int fcnt;
    } mstate_t;

    mstate_t ms4, ms1;
    bit      mvalid;

    pipeline_ctrl #(.MD_LAT(4), .CNT_W(CNT_W)) u_dut4 (
        .clk(clk), .rst(rst),
        .hd_stall_i(hd_stall_i), .if_miss_i(if_miss_i), .mem_busy_i(mem_busy_i),
        .redirect_i(redirect_i), .md_start_i(md_start_i),
        .pc_write_o(o4[9]), .if_id_write_o(o4[8]), .id_ex_write_o(o4[7]),
        .ex_mem_write_o(o4[6]), .mem_wb_write_o(o4[5]),
        .if_id_flush_o(o4[4]), .id_ex_bubble_o(o4[3]), .ex_mem_bubble_o(o4[2]),
        .mem_wb_bubble_o(o4[1]), .md_done_o(o4[0]),
        .stall_cnt_o(sc4), .flush_cnt_o(fc4)
    );

    pipeline_ctrl #(.MD_LAT(1), .CNT_W(CNT_W)) u_dut1 (
        .clk(clk), .rst(rst),
        .hd_stall_i(hd_stall_i), .if_miss_i(if_miss_i), .mem_busy_i(mem_busy_i),
        .redirect_i(redirect_i), .md_start_i(md_start_i),
        .pc_write_o(o1[9]), .if_id_write_o(o1[8]), .id_ex_write_o(o1[7]),
        .ex_mem_write_o(o1[6]), .mem_wb_write_o(o1[5]),
        .if_id_flush_o(o1[4]), .id_ex_bubble_o(o1[3]), .ex_mem_bubble_o(o1[2]),
        .mem_wb_bubble_o(o1[1]), .md_done_o(o1[0]),
        .stall_cnt_o(sc1), .flush_cnt_o(fc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    // Reference: one cycle of the controller, from the priority rules.
    task automatic model_step(input int lat, input bit rn, h, m, b, r, s,
                              input mstate_t cur, output logic [9:0] exp,
                              output mstate_t nxt);
        bit pc, iw, xw, mw, ww, fl, ib, mb, wb, dn, md_stall, took_redir;
        nxt = cur;
        if (!rn) begin
            exp = 10'b00000_11110;
            nxt = '{md_left: 0, drop: 1'b0, scnt: 0, fcnt: 0};
            return;
        end
        dn       = (lat == 1) ? s : (cur.md_left == 1);
        md_stall = (cur.md_left > 1) || (cur.md_left == 0 && s && lat > 1);
        {pc, iw, xw, mw, ww} = 5'b11111;
        {fl, ib, mb, wb}     = 4'b0000;
        took_redir = 1'b0;
        if (b) begin
            pc = 0; iw = 0; xw = 0; mw = 0; wb = 1;
        end else if (md_stall) begin
            pc = 0; iw = 0; xw = 0; mb = 1;
        end else if (r) begin
            fl = 1; ib = 1; took_redir = 1; nxt.drop = m;
        end else if (cur.drop && !m) begin
            fl = 1; nxt.drop = 0;
        end else if (h) begin
            pc = 0; iw = 0; ib = 1;
        end else if (m) begin
            pc = 0; fl = 1;
        end
        if (lat > 1) begin
            if (cur.md_left == 0)     nxt.md_left = (s && !b) ? lat - 1 : 0;
            else if (cur.md_left > 1) nxt.md_left = cur.md_left - 1;
            else                      nxt.md_left = b ? 1 : 0;
        end
        if (!pc)        nxt.scnt = sat(cur.scnt);
        if (took_redir) nxt.fcnt = sat(cur.fcnt);
        exp = {pc, iw, xw, mw, ww, fl, ib, mb, wb, dn};
    endtask

    task automatic apply(input bit rn, h, m, b, r, s);
        logic [9:0] e4, e1;
        mstate_t    n4, n1;
        @(negedge clk);
        rst = rn; hd_stall_i = h; if_miss_i = m; mem_busy_i = b;
        redirect_i = r; md_start_i = s;
        #1;
        model_step(4, rn, h, m, b, r, s, ms4, e4, n4);
        model_step(1, rn, h, m, b, r, s, ms1, e1, n1);
        check("outs_lat4", {22'd0, o4}, {22'd0, e4});
        check("outs_lat1", {22'd0, o1}, {22'd0, e1});
        if (mvalid) begin
            check("stall_cnt_lat4", {28'd0, sc4}, 32'(ms4.scnt));
            check("flush_cnt_lat4", {28'd0, fc4}, 32'(ms4.fcnt));
            check("stall_cnt_lat1", {28'd0, sc1}, 32'(ms1.scnt));
            check("flush_cnt_lat1", {28'd0, fc1}, 32'(ms1.fcnt));
        end
        ms4 = n4;
        ms1 = n1;
        if (!rn) mvalid = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_vec = 0; n_fail = 0; mvalid = 1'b0;
        ms4 = '{md_left: 0, drop: 1'b0, scnt: 0, fcnt: 0};
        ms1 = ms4;
        rst = 1'b0; hd_stall_i = 0; if_miss_i = 0; mem_busy_i = 0;
        redirect_i = 0; md_start_i = 0;

        apply(0, 0, 0, 0, 0, 0);
        apply(0, 1, 1, 1, 1, 1);

        // Single load-use stall cycle.
        apply(1, 1, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        check("t1_stall_cnt", {28'd0, sc4}, 32'd1);

        // mul/div pulse: three stall cycles, done on the fourth.
        apply(1, 0, 0, 0, 0, 1);
        idle(4);

        // mul/div caught by a 6-cycle MEM wait starting in its third cycle.
        apply(1, 0, 0, 0, 0, 1);
        apply(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) apply(1, 0, 0, 1, 0, 0);
        idle(2);

        // Redirect during a fetch miss; response arrives three cycles later.
        apply(0, 0, 0, 0, 0, 0);
        apply(1, 0, 1, 0, 1, 0);
        apply(1, 0, 1, 0, 0, 0);
        apply(1, 0, 1, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        check("t4_flush_cnt", {28'd0, fc4}, 32'd1);
        apply(1, 0, 0, 0, 0, 0);

        // Redirect and load-use in the same cycle.
        apply(1, 1, 0, 0, 1, 0);
        idle(1);

        // Reset while the mul/div is busy and a discard is pending.
        apply(1, 0, 1, 0, 1, 0);
        apply(1, 0, 0, 0, 0, 1);
        apply(0, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        check("t6_stall_cnt", {28'd0, sc4}, 32'd0);
        check("t6_flush_cnt", {28'd0, fc4}, 32'd0);

        // Random traffic; long enough to drive both counters into saturation.
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 99) < 20),
                  ($urandom_range(0, 99) < 25),
                  ($urandom_range(0, 99) < 15),
                  ($urandom_range(0, 99) < 12),
                  ($urandom_range(0, 99) < 10));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
